// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-side bundle for serial_frame_tx.
// The master modport is the word source; the slave modport is the transmitter.
interface serial_frame_tx_if #(
  parameter int DATA_LENGTH = 4
);
  logic [DATA_LENGTH-1:0] data_in;
  logic                   valid;
  logic                   ready;
  logic                   serial_out;
  logic                   shift_en;
  logic                   sel;
  logic                   busy;
  logic                   done;

  modport master (
    output data_in, valid,
    input  ready, serial_out, shift_en, sel, busy, done
  );

  modport slave (
    input  data_in, valid,
    output ready, serial_out, shift_en, sel, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define SERIAL_TX_PARITY_EN to insert the one-cycle parity state between data and stop.
module serial_frame_tx #(
  parameter int DATA_LENGTH = 4,
  parameter int STOP_BITS   = 1
) (
  input logic          clk,
  input logic          reset,
  serial_frame_tx_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_LENGTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state_q, state_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic [DATA_LENGTH-1:0] buf_q, buf_n;
  logic                   ser_q, ser_n;
  logic                   sen_q, sen_n;
  logic                   busy_q, busy_n;
  logic                   done_q, done_n;
  logic                   ready_w;
`ifdef SERIAL_TX_PARITY_EN
  logic                   par_q, par_n;
`endif

  // ready is a decode of the registered state, held low while reset is asserted
  assign ready_w        = (state_q == IDLE) && !reset;
  assign bus.ready      = ready_w;
  assign bus.serial_out = ser_q;
  assign bus.shift_en   = sen_q;
  assign bus.sel        = sen_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      ser_q   <= 1'b1;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      buf_q   <= buf_n;
      ser_q   <= ser_n;
      sen_q   <= sen_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // Outputs are decoded for the state being entered so they register alongside it
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    buf_n   = buf_q;
    ser_n   = 1'b1;
    sen_n   = 1'b0;
    done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.valid && ready_w) begin
          buf_n   = bus.data_in;
          cnt_n   = '0;
          ser_n   = 1'b0;
          state_n = START;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = ^bus.data_in;
`endif
        end
      end
      START: begin
        ser_n   = buf_q[0];
        sen_n   = 1'b1;
        state_n = DATA;
      end
      DATA: begin
        buf_n = buf_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
          ser_n   = par_q;
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          // buf_q[1] is the bit that sits at buf[0] once this cycle's shift lands
          cnt_n = cnt_q + 1'b1;
          ser_n = buf_q[1];
          sen_n = 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        cnt_n   = '0;
        state_n = STOP;
      end
`endif
      STOP: begin
        if (cnt_q == LAST_STOP) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed table-driven bench for serial_frame_tx with a model of the downstream shift register.
// Two instances: STOP_BITS=1 for most vectors and STOP_BITS=2 for the double-stop case.
module tb_serial_frame_tx;
  localparam int DL = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LEN1 = 1 + DL + P + 1;
  localparam int LEN2 = LEN1 + 1;
  localparam logic [7:0] SEN = 8'b0001_1110;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_LENGTH(DL)) b1 ();
  serial_frame_tx_if #(.DATA_LENGTH(DL)) b2 ();

  serial_frame_tx #(.DATA_LENGTH(DL), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .bus(b1)
  );
  serial_frame_tx #(.DATA_LENGTH(DL), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic [DL-1:0] sr1 = '0;
  logic [DL-1:0] sr2 = '0;
  always @(posedge clk) begin
    if (b1.shift_en) sr1 <= {b1.serial_out, sr1[DL-1:1]};
    if (b2.shift_en) sr2 <= {b2.serial_out, sr2[DL-1:1]};
  end

  typedef struct {
    string         name;
    logic [DL-1:0] data;
    logic [7:0]    ser;
  } vec_t;
  vec_t vecs [5];

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic o_ser();   return cur == 0 ? b1.serial_out : b2.serial_out; endfunction
  function automatic logic o_sen();   return cur == 0 ? b1.shift_en   : b2.shift_en;   endfunction
  function automatic logic o_sel();   return cur == 0 ? b1.sel        : b2.sel;        endfunction
  function automatic logic o_busy();  return cur == 0 ? b1.busy       : b2.busy;       endfunction
  function automatic logic o_done();  return cur == 0 ? b1.done       : b2.done;       endfunction
  function automatic logic o_ready(); return cur == 0 ? b1.ready      : b2.ready;      endfunction
  function automatic logic [DL-1:0] o_sr(); return cur == 0 ? sr1 : sr2; endfunction

  task automatic drive(input logic v, input logic [DL-1:0] d);
    if (cur == 0) begin
      b1.valid = v; b1.data_in = d;
    end else begin
      b2.valid = v; b2.data_in = d;
    end
  endtask

  // Leaves the bench at the falling edge inside the START cycle
  task automatic start(input string name, input logic [DL-1:0] word);
    @(negedge clk);
    chkb({name, ".ready_idle"}, o_ready(), 1'b1);
    drive(1'b1, word);
    @(negedge clk);
    drive(1'b0, ~word);
  endtask

  // Entered in the START cycle; returns in the done cycle
  task automatic run_frame(input string name, input logic [7:0] exp_ser, input int len,
                           input logic [DL-1:0] exp_word, input bit hold);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      chkb($sformatf("%s.ser%0d", name, i), o_ser(), exp_ser[i]);
      chkb($sformatf("%s.sen%0d", name, i), o_sen(), SEN[i]);
      chkb($sformatf("%s.sel%0d", name, i), o_sel(), SEN[i]);
      chkb($sformatf("%s.busy%0d", name, i), o_busy(), 1'b1);
      chkb($sformatf("%s.ready%0d", name, i), o_ready(), 1'b0);
      chkb($sformatf("%s.done%0d", name, i), o_done(), 1'b0);
      if (hold) drive(1'b1, DL'($urandom));
    end
    @(negedge clk);
    chkb({name, ".done"}, o_done(), 1'b1);
    chkb({name, ".ready_done"}, o_ready(), 1'b1);
    chkb({name, ".ser_done"}, o_ser(), 1'b1);
    chkb({name, ".busy_done"}, o_busy(), 1'b0);
    chkw({name, ".sr"}, o_sr(), exp_word);
  endtask

  task automatic idle_after(input string name);
    @(negedge clk);
    chkb({name, ".done_clr"}, o_done(), 1'b0);
    chkb({name, ".ser_idle"}, o_ser(), 1'b1);
    chkb({name, ".busy_idle"}, o_busy(), 1'b0);
  endtask

  initial begin
`ifdef SERIAL_TX_PARITY_EN
    vecs[0] = '{"w1011", 4'b1011, 8'h76};
    vecs[1] = '{"w1001", 4'b1001, 8'h52};
    vecs[2] = '{"w0110", 4'b0110, 8'h4C};
    vecs[3] = '{"w1111", 4'b1111, 8'h5E};
    vecs[4] = '{"w0000", 4'b0000, 8'h40};
`else
    vecs[0] = '{"w1011", 4'b1011, 8'h36};
    vecs[1] = '{"w1001", 4'b1001, 8'h32};
    vecs[2] = '{"w0110", 4'b0110, 8'h2C};
    vecs[3] = '{"w1111", 4'b1111, 8'h3E};
    vecs[4] = '{"w0000", 4'b0000, 8'h20};
`endif
    b1.valid = 1'b0; b1.data_in = '0;
    b2.valid = 1'b0; b2.data_in = '0;

    // reset asserted between edges must take effect at once
    #2 reset = 1'b1;
    #1;
    chkb("rst.ser", b1.serial_out, 1'b1);
    chkb("rst.sen", b1.shift_en, 1'b0);
    chkb("rst.sel", b1.sel, 1'b0);
    chkb("rst.busy", b1.busy, 1'b0);
    chkb("rst.done", b1.done, 1'b0);
    chkb("rst.ready", b1.ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chkb("rst.ready_rel", b1.ready, 1'b1);

    cur = 0;
    foreach (vecs[k]) begin
      start(vecs[k].name, vecs[k].data);
      run_frame(vecs[k].name, vecs[k].ser, LEN1, vecs[k].data, 1'b0);
      idle_after(vecs[k].name);
    end

    // valid held high across two frames, data_in churning mid-frame
    @(negedge clk);
    drive(1'b1, vecs[0].data);
    @(negedge clk);
    run_frame("hold_a", vecs[0].ser, LEN1, vecs[0].data, 1'b1);
    drive(1'b1, vecs[2].data);
    @(negedge clk);
    run_frame("hold_b", vecs[2].ser, LEN1, vecs[2].data, 1'b1);
    drive(1'b0, '0);
    idle_after("hold_b");

    // reset while in the DATA state after two bits have gone out
    start("midrst", 4'b1011);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chkb("midrst.sen_pre", b1.shift_en, 1'b1);
    reset = 1'b1;
    #1;
    chkb("midrst.ser", b1.serial_out, 1'b1);
    chkb("midrst.sen", b1.shift_en, 1'b0);
    chkb("midrst.busy", b1.busy, 1'b0);
    chkb("midrst.done", b1.done, 1'b0);
    chkb("midrst.ready", b1.ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chkb("midrst.ready_rel", b1.ready, 1'b1);
    idle_after("midrst");
    start("after_rst", vecs[2].data);
    run_frame("after_rst", vecs[2].ser, LEN1, vecs[2].data, 1'b0);
    idle_after("after_rst");

    // two stop bits
    cur = 1;
    start("stop2", 4'b0000);
`ifdef SERIAL_TX_PARITY_EN
    run_frame("stop2", 8'hC0, LEN2, 4'b0000, 1'b0);
`else
    run_frame("stop2", 8'h60, LEN2, 4'b0000, 1'b0);
`endif
    idle_after("stop2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
